pwm_audio_modulator: RTL and testbench

Downstream audio output stage. Accepts 11-bit unsigned sine samples from the note/sample generator over a valid/ready handshake, holds them in a one-entry pending buffer, and converts each sample into one fixed-length PWM frame on the audio pin. The sample generator paces itself by the back-pressure; it no longer owns a free-running clock divider.

---
 rtl/pwm_audio_pkg.sv | 27 ++
 rtl/pwm_pending_buf.sv | 65 ++++++
 rtl/pwm_audio_modulator.sv | 127 ++++++++++++
 tb/tb_pwm_audio_modulator.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_audio_pkg
// Description : Shared constants and helpers for the PWM audio output stage.
//               Provides the default sample width, the frame length,
//               midscale and the underrun counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_audio_pkg;

    // Frame length in clocks for a given sample width.
    function automatic int unsigned pwm_frame_len(input int unsigned w);
        return 32'd1 << w;
    endfunction

    // Midscale code (silence) for a given sample width.
    function automatic int unsigned pwm_midscale(input int unsigned w);
        return 32'd1 << (w - 32'd1);
    endfunction

    localparam int unsigned PWM_SAMPLE_W  = 11;
    localparam int unsigned PWM_UCNT_W    = 16;
    localparam int unsigned PWM_FRAME_LEN = pwm_frame_len(PWM_SAMPLE_W);
    localparam int unsigned PWM_MIDSCALE  = pwm_midscale(PWM_SAMPLE_W);

endpackage
`default_nettype wire

// File: rtl/pwm_pending_buf.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pending_buf
// Description : One-entry pending sample buffer between the sample generator
//               and the PWM active register. Produces s_ready, accepts
//               samples, and hands the held sample over on the reload edge
//               (or flags an underrun when nothing is held).
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_pending_buf
    import pwm_audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W = PWM_SAMPLE_W
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                reload_i,
    input  logic [SAMPLE_W-1:0] s_data_i,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    output logic                load_o,
    output logic [SAMPLE_W-1:0] load_data_o,
    output logic                underrun_o
);

    logic                full_q;
    logic                full_d;
    logic [SAMPLE_W-1:0] data_q;
    logic [SAMPLE_W-1:0] data_d;
    logic                w_xfer;

    // Ready depends only on state and the reload edge, never on s_valid,
    // so the producer can never form a combinational loop through us.
    assign s_ready_o   = !full_q || reload_i;
    assign w_xfer      = s_valid_i && s_ready_o;
    assign load_o      = reload_i && full_q;
    assign underrun_o  = reload_i && !full_q;
    assign load_data_o = data_q;

    // Next-state: a transfer always lands in pending (no bypass to active);
    // a reload without a transfer drains the buffer.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (w_xfer) begin
            full_d = 1'b1;
            data_d = s_data_i;
        end else if (reload_i) begin
            full_d = 1'b0;
        end
    end

    // Pending buffer state; reset discards any held sample.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_audio_modulator.sv
`default_nettype none
// ============================================================================
// Module      : pwm_audio_modulator
// Description : Audio PWM output stage. Each accepted sample becomes one
//               2**SAMPLE_W-clock PWM frame on pwm_out. Samples arrive over a
//               valid/ready handshake into a one-entry pending buffer and
//               move into the active register at each frame wrap.
// Config      : PWM_UNDERRUN_MUTE_EN - when defined, an underrun loads
//               midscale (silence); otherwise the last sample repeats.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_audio_modulator
    import pwm_audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W = PWM_SAMPLE_W,
    parameter int unsigned UCNT_W   = PWM_UCNT_W
) (
    input  logic                CLK100MHZ,
    input  logic                CPU_RESETN,
    input  logic [SAMPLE_W-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                pwm_out,
    output logic                frame_start,
    output logic                underrun,
    output logic [UCNT_W-1:0]   underrun_cnt
);

    localparam logic [SAMPLE_W-1:0] MIDSCALE = SAMPLE_W'(pwm_midscale(SAMPLE_W));
    localparam logic [SAMPLE_W-1:0] CNT_MAX  = SAMPLE_W'(pwm_frame_len(SAMPLE_W) - 32'd1);

    // started_q is low only for the first clock after reset release: that
    // clock holds cnt at 0 and raises frame_start so the first frame begins
    // with a visible frame_start and the first reload is a full frame later.
    logic                started_q;
    logic                started_d;
    logic [SAMPLE_W-1:0] cnt_q;
    logic [SAMPLE_W-1:0] cnt_d;
    logic [SAMPLE_W-1:0] active_q;
    logic [SAMPLE_W-1:0] active_d;
    logic                pwm_q;
    logic                pwm_d;
    logic                fs_q;
    logic                fs_d;
    logic                und_q;
    logic                und_d;
    logic [UCNT_W-1:0]   ucnt_q;
    logic [UCNT_W-1:0]   ucnt_d;

    logic                w_reload;
    logic                w_load;
    logic                w_underrun;
    logic [SAMPLE_W-1:0] w_load_data;

    // The wrap edge (cnt at its maximum) is the only reload edge.
    assign w_reload = (cnt_q == CNT_MAX);

    pwm_pending_buf #(
        .SAMPLE_W (SAMPLE_W)
    ) u_pending (
        .clk_i       (CLK100MHZ),
        .rst_ni      (CPU_RESETN),
        .reload_i    (w_reload),
        .s_data_i    (s_data),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready),
        .load_o      (w_load),
        .load_data_o (w_load_data),
        .underrun_o  (w_underrun)
    );

    // Next-state for the frame counter, active sample, compare and status.
    always_comb begin
        started_d = 1'b1;
        cnt_d     = started_q ? (cnt_q + 1'b1) : cnt_q;
        fs_d      = !started_q || w_reload;
        und_d     = w_underrun;

        ucnt_d = ucnt_q;
        if (w_underrun && (ucnt_q != {UCNT_W{1'b1}})) begin
            ucnt_d = ucnt_q + 1'b1;
        end

        active_d = active_q;
        if (w_load) begin
            active_d = w_load_data;
        end
`ifdef PWM_UNDERRUN_MUTE_EN
        if (w_underrun) begin
            active_d = MIDSCALE;
        end
`endif

        // Registered compare: pwm for counter value N appears one clock
        // later, so a new sample shows up the cycle after frame_start and
        // stays high for exactly active clocks.
        pwm_d = started_q && (cnt_q < active_q);
    end

    // Datapath and status registers; everything clears asynchronously.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            started_q <= 1'b0;
            cnt_q     <= '0;
            active_q  <= MIDSCALE;
            pwm_q     <= 1'b0;
            fs_q      <= 1'b0;
            und_q     <= 1'b0;
            ucnt_q    <= '0;
        end else begin
            started_q <= started_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            pwm_q     <= pwm_d;
            fs_q      <= fs_d;
            und_q     <= und_d;
            ucnt_q    <= ucnt_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign frame_start  = fs_q;
    assign underrun     = und_q;
    assign underrun_cnt = ucnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_audio_modulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_audio_modulator
// Description : Scoreboard bench for pwm_audio_modulator. Stimulus pushes the
//               expected per-frame result (high clocks of the frame that just
//               ended, underrun flag, underrun count); a monitor pops and
//               compares at every frame_start. A small second instance
//               (4-bit samples, 2-bit counter) checks counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_audio_modulator;
    import pwm_audio_pkg::*;

`ifdef PWM_UNDERRUN_MUTE_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif
    localparam int MID  = int'(PWM_MIDSCALE);
    localparam int LAST = int'(PWM_FRAME_LEN) - 1;
    localparam int WAIT_BOUND = 7000;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [10:0] s_data  = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        pwm_out;
    logic        frame_start;
    logic        underrun;
    logic [15:0] ucnt;

    logic [3:0]  sm_data  = '0;
    logic        sm_valid = 1'b0;
    logic        sm_ready;
    logic        sm_pwm;
    logic        sm_fs;
    logic        sm_und;
    logic [1:0]  sm_ucnt;

    always #5 clk = ~clk;

    pwm_audio_modulator dut (
        .CLK100MHZ    (clk),
        .CPU_RESETN   (rst_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .pwm_out      (pwm_out),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .underrun_cnt (ucnt)
    );

    pwm_audio_modulator #(.SAMPLE_W(4), .UCNT_W(2)) dut_small (
        .CLK100MHZ    (clk),
        .CPU_RESETN   (rst_n),
        .s_data       (sm_data),
        .s_valid      (sm_valid),
        .s_ready      (sm_ready),
        .pwm_out      (sm_pwm),
        .frame_start  (sm_fs),
        .underrun     (sm_und),
        .underrun_cnt (sm_ucnt)
    );

    typedef struct {
        bit chk_hi;
        int hi;
        bit und;
        int ucnt;
    } frame_t;

    frame_t exp_q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic expect_frame(input bit chk_hi, input int hi, input bit und, input int uc);
        frame_t r;
        r.chk_hi = chk_hi;
        r.hi     = hi;
        r.und    = und;
        r.ucnt   = uc;
        exp_q.push_back(r);
    endtask

    // Frame position tracker used only to time stimulus.
    int fnum = -1;
    int tcnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            fnum = -1;
            tcnt = 0;
        end else if (frame_start) begin
            fnum = fnum + 1;
            tcnt = 0;
        end else begin
            tcnt = tcnt + 1;
        end
    end

    // Monitor: measures each frame window (cycle after frame_start through
    // the next frame_start) and checks against the scoreboard.
    int hi_cnt     = 0;
    bit have_frame = 1'b0;
    bit seen_low   = 1'b0;
    bit shape_bad  = 1'b0;
    initial begin : monitor
        frame_t r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_frame = 1'b0;
                hi_cnt     = 0;
                seen_low   = 1'b0;
                shape_bad  = 1'b0;
            end else if (frame_start) begin
                if (have_frame && pwm_out) begin
                    hi_cnt++;
                    if (seen_low) shape_bad = 1'b1;
                end
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: got frame_start %0d with nothing queued, required none", fnum);
                end else begin
                    r = exp_q.pop_front();
                    check("frame_underrun", underrun, r.und);
                    check("frame_ucnt", ucnt, r.ucnt);
                    if (r.chk_hi) begin
                        check("frame_seen", have_frame, 1);
                        check("frame_high_clocks", hi_cnt, r.hi);
                        check("frame_shape_bad", shape_bad, 0);
                    end
                end
                have_frame = 1'b1;
                hi_cnt     = 0;
                seen_low   = 1'b0;
                shape_bad  = 1'b0;
            end else begin
                if (underrun) begin
                    tests++;
                    fails++;
                    $display("FAIL stray_underrun: got underrun=1 outside frame_start, required 0");
                end
                if (have_frame) begin
                    if (pwm_out) begin
                        hi_cnt++;
                        if (seen_low) shape_bad = 1'b1;
                    end else begin
                        seen_low = 1'b1;
                    end
                end
            end
        end
    end

    // Wait for the cycle with frame number f and counter c; bounded.
    task automatic wait_at(input int f, input int c);
        for (int i = 0; i < WAIT_BOUND; i++) begin
            @(negedge clk);
            #1;
            if (fnum == f && tcnt == c) return;
        end
        tests++;
        fails++;
        $display("FAIL wait_timeout: got frame %0d cnt %0d, required frame %0d cnt %0d", fnum, tcnt, f, c);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        check("leftover_frames", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #1;
        check("rst_pwm_out", pwm_out, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_underrun", underrun, 0);
        check("rst_ucnt", ucnt, 0);
        check("rst_s_ready", s_ready, 1);
        check("rst_small_ucnt", sm_ucnt, 0);
        check("rst_small_pwm", sm_pwm, 0);
        check("rst_small_fs", sm_fs, 0);
        check("rst_small_und", sm_und, 0);
        check("rst_small_ready", sm_ready, 1);
        expect_frame(1'b0, 0, 1'b0, 0);
        rst_n = 1'b1;
    endtask

    initial begin : stimulus
        // Idle producer: midscale frames, one underrun per frame.
        do_reset();
        expect_frame(1'b1, MID, 1'b1, 1);
        expect_frame(1'b1, MID, 1'b1, 2);
        expect_frame(1'b1, MID, 1'b1, 3);
        wait_at(0, 100);  check("t1_ready_f0", s_ready, 1);
        wait_at(1, 100);  check("t1_ready_f1", s_ready, 1);
        wait_at(2, LAST); check("t1_ready_f2", s_ready, 1);
        wait_at(3, 5);    check("t1_small_ucnt_sat", sm_ucnt, 3);

        // Single 512 sample written at cnt=10.
        do_reset();
        expect_frame(1'b1, MID, 1'b0, 0);
        expect_frame(1'b1, 512, 1'b1, 1);
        wait_at(0, 10); check("t2_ready_before", s_ready, 1);
        s_valid = 1'b1; s_data = 11'd512;
        wait_at(0, 11); s_valid = 1'b0; check("t2_ready_after", s_ready, 0);
        wait_at(1, 3);  check("t2_ready_drained", s_ready, 1);
        wait_at(2, 5);

        // 0 then 2047 presented on consecutive reload edges.
        do_reset();
        expect_frame(1'b1, MID, 1'b1, 1);
        expect_frame(1'b1, MID, 1'b0, 1);
        expect_frame(1'b1, 0, 1'b0, 1);
        expect_frame(1'b1, 2047, 1'b1, 2);
        wait_at(0, LAST); check("t3_ready_edge1", s_ready, 1);
        s_valid = 1'b1; s_data = 11'd0;
        wait_at(1, 0);    s_valid = 1'b0; check("t3_ready_full1", s_ready, 0);
        wait_at(1, LAST); check("t3_ready_edge2", s_ready, 1);
        s_valid = 1'b1; s_data = 11'd2047;
        wait_at(2, 0);    s_valid = 1'b0; check("t3_ready_full2", s_ready, 0);
        wait_at(4, 5);

        // 100 at cnt=50, then 200 held until accepted at the reload edge.
        do_reset();
        expect_frame(1'b1, MID, 1'b0, 0);
        expect_frame(1'b1, 100, 1'b0, 0);
        expect_frame(1'b1, 200, 1'b1, 1);
        wait_at(0, 50);   check("t4_ready_50", s_ready, 1);
        s_valid = 1'b1; s_data = 11'd100;
        wait_at(0, 51);   check("t4_ready_51", s_ready, 0);
        s_data = 11'd200;
        wait_at(0, 1000); check("t4_ready_1000", s_ready, 0);
        wait_at(0, LAST); check("t4_ready_edge", s_ready, 1);
        wait_at(1, 0);    s_valid = 1'b0; check("t4_ready_after", s_ready, 0);
        wait_at(3, 5);

        // 300 then stop: repeat or mute after the underrun.
        do_reset();
        expect_frame(1'b1, MID, 1'b0, 0);
        expect_frame(1'b1, 300, 1'b1, 1);
        expect_frame(1'b1, MUTE ? MID : 300, 1'b1, 2);
        wait_at(0, 20); s_valid = 1'b1; s_data = 11'd300;
        wait_at(0, 21); s_valid = 1'b0;
        wait_at(3, 5);

        // Reset mid-frame with a pending sample that must never play.
        do_reset();
        expect_frame(1'b1, MID, 1'b1, 1);
        wait_at(1, 10);  s_valid = 1'b1; s_data = 11'd400;
        wait_at(1, 11);  s_valid = 1'b0;
        wait_at(1, 700);
        check("t6_pre_pwm", pwm_out, 1);
        check("t6_pre_ucnt", ucnt, 1);
        check("t6_pre_ready", s_ready, 0);
        rst_n = 1'b0;
        #1;
        check("t6_async_pwm", pwm_out, 0);
        check("t6_async_ucnt", ucnt, 0);
        check("t6_async_ready", s_ready, 1);
        do_reset();
        expect_frame(1'b1, MID, 1'b1, 1);
        expect_frame(1'b1, MID, 1'b1, 2);
        wait_at(2, 5);

        check("final_queue", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
